// File: rtl/adpll_pkg.sv
// Shared gear encoding and per-gear PI gain constants for the ADPLL gear controller.
package adpll_pkg;

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned GAIN_W = 5;

  localparam logic [1:0] GEAR_ACQ    = 2'd0;
  localparam logic [1:0] GEAR_COARSE = 2'd1;
  localparam logic [1:0] GEAR_FINE   = 2'd2;
  localparam logic [1:0] GEAR_LOCKED = 2'd3;

  localparam logic [GAIN_W-1:0] ALPHA_ACQ    = 5'd4;
  localparam logic [GAIN_W-1:0] BETA_ACQ     = 5'd8;
  localparam logic [GAIN_W-1:0] ALPHA_COARSE = 5'd2;
  localparam logic [GAIN_W-1:0] BETA_COARSE  = 5'd4;
  localparam logic [GAIN_W-1:0] ALPHA_FINE   = 5'd1;
  localparam logic [GAIN_W-1:0] BETA_FINE    = 5'd2;

  function automatic logic [GAIN_W-1:0] gear_alpha(input logic [1:0] g);
    case (g)
      GEAR_ACQ:    gear_alpha = ALPHA_ACQ;
      GEAR_COARSE: gear_alpha = ALPHA_COARSE;
      default:     gear_alpha = ALPHA_FINE;
    endcase
  endfunction

  function automatic logic [GAIN_W-1:0] gear_beta(input logic [1:0] g);
    case (g)
      GEAR_ACQ:    gear_beta = BETA_ACQ;
      GEAR_COARSE: gear_beta = BETA_COARSE;
      default:     gear_beta = BETA_FINE;
    endcase
  endfunction

endpackage

// File: rtl/adpll_sat_cnt.sv
// 5-bit saturating up-counter; clear wins over increment.
module adpll_sat_cnt
  import adpll_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adpll_gear_ctrl.sv
// ADPLL gear-shift controller: steps PI gains ACQ->COARSE->FINE->LOCKED on sustained small error.
// Optional loss-of-lock detection back to ACQ is enabled by defining ADPLL_LOSS_DETECT_EN.
module adpll_gear_ctrl
  import adpll_pkg::*;
#(
  parameter int unsigned LOCK_CNT      = 16,
  parameter int unsigned UNLOCK_CNT    = 4,
  parameter int unsigned ERR_LOCK_TH   = 2,
  parameter int unsigned ERR_UNLOCK_TH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       error_valid,
  input  logic       error_sign,
  input  logic [4:0] error,
  output logic [4:0] alpha_var,
  output logic [4:0] beta_var,
  output logic [1:0] gear,
  output logic       locked,
  output logic       integ_clear
);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] in_cnt;
  logic             in_band;
  logic             advance;
  logic             loss;
  logic             unused_cfg;

  assign in_band = (error <= 5'(ERR_LOCK_TH));
  assign gear    = state_q;

`ifdef ADPLL_LOSS_DETECT_EN
  logic [CNT_W-1:0] out_cnt;
  logic             out_band;
  logic             integ_clear_q;

  assign out_band   = (error > 5'(ERR_UNLOCK_TH));
  assign loss       = error_valid && out_band && (state_q != GEAR_ACQ)
                      && (out_cnt == 5'(UNLOCK_CNT - 1));
  assign unused_cfg = error_sign;

  adpll_sat_cnt u_out_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (error_valid && out_band),
    .clr   (error_valid && (!out_band || loss)),
    .count (out_cnt)
  );

  // Integrator clear accompanies the drop to ACQ for exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) integ_clear_q <= 1'b0;
    else       integ_clear_q <= loss;
  end
  assign integ_clear = integ_clear_q;
`else
  assign loss        = 1'b0;
  assign integ_clear = 1'b0;
  assign unused_cfg  = ^{error_sign, 5'(UNLOCK_CNT), 5'(ERR_UNLOCK_TH)};
`endif

  adpll_sat_cnt u_in_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (error_valid && in_band),
    .clr   (error_valid && (!in_band || advance || loss)),
    .count (in_cnt)
  );

  // Next-gear decode; loss of lock outranks a gear advance.
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    if (loss) begin
      state_d = GEAR_ACQ;
    end else if (error_valid && in_band && (state_q != GEAR_LOCKED)
                 && (in_cnt == 5'(LOCK_CNT - 1))) begin
      advance = 1'b1;
      state_d = state_q + 2'd1;
    end
  end

  // Gains and locked are registered alongside the state so all change on one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= GEAR_ACQ;
      alpha_var <= ALPHA_ACQ;
      beta_var  <= BETA_ACQ;
      locked    <= 1'b0;
    end else begin
      state_q   <= state_d;
      alpha_var <= gear_alpha(state_d);
      beta_var  <= gear_beta(state_d);
      locked    <= (state_d == GEAR_LOCKED);
    end
  end

endmodule

// File: doc/adpll_gear_ctrl.md
ADPLL_GEAR_CTRL -- requirements
Module: adpll_gear_ctrl

Interface
REQ-001 Parameter LOCK_CNT, default 16, consecutive in-band samples needed to advance one gear (range 1..31).
REQ-002 Parameter UNLOCK_CNT, default 4, consecutive out-of-band samples that declare loss of lock (range 1..31).
REQ-003 Parameter ERR_LOCK_TH, default 2, in-band limit on |error|: in-band when |error| <= ERR_LOCK_TH.
REQ-004 Parameter ERR_UNLOCK_TH, default 8, out-of-band limit on |error|: out-of-band when |error| > ERR_UNLOCK_TH; ERR_UNLOCK_TH >= ERR_LOCK_TH.
REQ-005 clk  input  1  single clock, rising-edge active.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 error_valid  input  1  one-cycle strobe; a new phase-error sample is present.
REQ-008 error_sign  input  1  phase-error sign; ignored by this block.
REQ-009 error  input  5  phase-error magnitude, sampled only when error_valid=1.
REQ-010 alpha_var  output  5  integral gain to the PI filter.
REQ-011 beta_var  output  5  proportional gain to the PI filter.
REQ-012 gear  output  2  current state: 0 ACQ, 1 COARSE, 2 FINE, 3 LOCKED.
REQ-013 locked  output  1  high only in LOCKED.
REQ-014 integ_clear  output  1  one-cycle pulse requesting an integrator clear in the PI filter.

Function
REQ-015 Gains SHALL be decoded from the registered state: ACQ alpha=4 beta=8; COARSE alpha=2 beta=4; FINE and LOCKED alpha=1 beta=2.
REQ-016 Gains SHALL change on the same clock edge as gear, with no intermediate values.
REQ-017 Samples with error_valid=0 SHALL leave all counters and the state unchanged.
REQ-018 Each valid in-band sample SHALL increment in_cnt, saturating at 31. Each valid non-in-band sample SHALL clear in_cnt.
REQ-019 Each valid out-of-band sample SHALL increment out_cnt, saturating at 31. Each valid non-out-of-band sample SHALL clear out_cnt.
REQ-020 Gear advance: when a valid in-band sample makes in_cnt reach LOCK_CNT in ACQ, COARSE or FINE, the state SHALL step to the next gear on that edge and in_cnt SHALL clear.
REQ-021 LOCKED SHALL be terminal for in-band samples; in_cnt saturates there.
REQ-022 Loss of lock (LOSS_DETECT_EN only): when a valid sample makes out_cnt reach UNLOCK_CNT in COARSE, FINE or LOCKED, the state SHALL go to ACQ.
REQ-023 On that loss-of-lock transition, both counters SHALL clear and integ_clear SHALL be high for exactly the next cycle.
REQ-024 In ACQ, out_cnt SHALL count but SHALL cause no transition and no integ_clear.
REQ-025 Loss of lock SHALL take priority over gear advance on the same edge; with the threshold constraint of REQ-004 the two cannot coincide.
REQ-026 Latency: the sample strobe that triggers a transition SHALL produce the new gear, gains and locked one cycle later.

Reset
REQ-027 Reset SHALL force asynchronously: gear=ACQ, alpha_var=4, beta_var=8, locked=0, integ_clear=0, in_cnt=0, out_cnt=0.
REQ-028 Reset mid-operation SHALL abort any pending count; the first valid sample after reset release SHALL be counted from zero.

Configuration
REQ-029 With macro ADPLL_LOSS_DETECT_EN defined, REQ-022 and REQ-023 SHALL apply.
REQ-030 Without ADPLL_LOSS_DETECT_EN, out_cnt logic SHALL be absent, LOCKED SHALL be sticky until reset, and integ_clear SHALL be tied 0.

Structure
REQ-031 A shared package adpll_pkg SHALL hold the gear state encoding and the per-gear alpha/beta constants.
REQ-032 A sub-module adpll_sat_cnt SHALL implement the 5-bit saturating counter with increment and clear inputs; it is instantiated for in_cnt and, when configured, for out_cnt.

Verification
REQ-033 Reset, then 16 valid samples with error=1 -> gear 0->1 one cycle after the 16th strobe, with alpha=2 and beta=4.
REQ-034 48 valid samples with error=2 -> gear reaches 3 and locked=1 after the 48th strobe, with alpha=1 and beta=2.
REQ-035 15 samples with error=1, then one with error=3, then 15 with error=1 -> gear stays 0.
REQ-036 From LOCKED, 4 valid samples with error=9 -> gear=0, alpha=4, beta=8, locked=0, and integ_clear pulses for one cycle; without the macro, the state stays LOCKED.
REQ-037 From LOCKED, 3 samples with error=9, one with error=5, then 3 with error=9 -> remains LOCKED.
REQ-038 Assert reset mid-count at in_cnt=10 in COARSE -> outputs at reset values, and the next 16 in-band samples are needed to leave ACQ.
